// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encodings,
// opcode/funct constants, datapath mux codes and the packed control word.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_ADDIEX = 4'd9,
    S_ADDIWB = 4'd10
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;

  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  localparam logic [2:0] ALUC_ADD = 3'b010;
  localparam logic [2:0] ALUC_SUB = 3'b110;
  localparam logic [2:0] ALUC_AND = 3'b000;
  localparam logic [2:0] ALUC_OR  = 3'b001;
  localparam logic [2:0] ALUC_SLT = 3'b111;

  localparam logic [1:0] SRCB_B       = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  // ALUOP_IDLE marks states where the ALU result is unused; it decodes to all-zero.
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10,
    ALUOP_IDLE  = 2'b11
  } aluop_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_src;
    logic       reg_write;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
  } ctrl_t;

  function automatic logic is_mem_op(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_SW);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle controller and the DataPath.
// master = controller (drives control lines), slave = DataPath side.
interface multicycle_control_if;
  logic [5:0] Op;
  logic [5:0] Funct;
  logic       Zero;
  logic       PCWrite;
  logic       PCSrc;
  logic       RegWrite;
  logic       IorD;
  logic       MemWrite;
  logic       IRWrite;
  logic       RegDst;
  logic       MemtoReg;
  logic       ALUSrcA;
  logic [1:0] ALUSrcB;
  logic [2:0] ALUControl;

  modport master (
    input  Op, Funct, Zero,
    output PCWrite, PCSrc, RegWrite, IorD, MemWrite, IRWrite,
           RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUControl
  );

  modport slave (
    output Op, Funct, Zero,
    input  PCWrite, PCSrc, RegWrite, IorD, MemWrite, IRWrite,
           RegDst, MemtoReg, ALUSrcA, ALUSrcB, ALUControl
  );
endinterface

// File: rtl/alu_decoder.sv
// Combinational map from the FSM's ALUOp plus the instruction funct field
// to the 3-bit ALUControl code.
module alu_decoder
  import mips_ctrl_pkg::*;
(
  input  aluop_t     aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alu_control_o
);

  always_comb begin
    alu_control_o = 3'b000;
    case (aluop_i)
      ALUOP_ADD: alu_control_o = ALUC_ADD;
      ALUOP_SUB: alu_control_o = ALUC_SUB;
      ALUOP_FUNCT: begin
        // Unknown functs fall back to add so write-back still produces a value.
        case (funct_i)
          FUNCT_ADD: alu_control_o = ALUC_ADD;
          FUNCT_SUB: alu_control_o = ALUC_SUB;
          FUNCT_AND: alu_control_o = ALUC_AND;
          FUNCT_OR:  alu_control_o = ALUC_OR;
          FUNCT_SLT: alu_control_o = ALUC_SLT;
          default:   alu_control_o = ALUC_ADD;
        endcase
      end
      default: alu_control_o = 3'b000;
    endcase
  end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Moore sequencer for the multicycle core: one microstep per clock, all
// control outputs decoded from the state register (PCWrite also sees Zero).
module multicycle_control_fsm
  import mips_ctrl_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  multicycle_control_if.master bus,
  output state_t              state_o
);

  state_t     state_q, state_d;
  ctrl_t      ctrl;
  aluop_t     aluop;
  logic [2:0] alu_control;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  // Op is stable from DECODE onward because IR only loads in FETCH.
  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (is_mem_op(bus.Op))       state_d = S_MEMADR;
        else if (bus.Op == OP_RTYPE) state_d = S_EXEC;
        else if (bus.Op == OP_BEQ)   state_d = S_BRANCH;
        else if (bus.Op == OP_ADDI)  state_d = S_ADDIEX;
        else                         state_d = S_FETCH;
      end
      S_MEMADR: state_d = (bus.Op == OP_LW) ? S_MEMRD : S_MEMWR;
      S_MEMRD:  state_d = S_MEMWB;
      S_MEMWB:  state_d = S_FETCH;
      S_MEMWR:  state_d = S_FETCH;
      S_EXEC:   state_d = S_ALUWB;
      S_ALUWB:  state_d = S_FETCH;
      S_BRANCH: state_d = S_FETCH;
      S_ADDIEX: state_d = S_ADDIWB;
      S_ADDIWB: state_d = S_FETCH;
      default:  state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ctrl  = '0;
    aluop = ALUOP_IDLE;
    case (state_q)
      S_FETCH: begin
        ctrl.ir_write  = 1'b1;
        ctrl.pc_write  = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        aluop          = ALUOP_ADD;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMM_SH2;
        aluop          = ALUOP_ADD;
      end
      S_MEMADR, S_ADDIEX: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_IMM;
        aluop          = ALUOP_ADD;
      end
      S_MEMRD: ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWR: begin
        ctrl.iord      = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXEC: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        aluop          = ALUOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst   = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = 1'b1;
        ctrl.alu_src_b = SRCB_B;
        ctrl.pc_src    = 1'b1;
        ctrl.pc_write  = bus.Zero;
        aluop          = ALUOP_SUB;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      default: ;
    endcase
  end

  alu_decoder u_alu_decoder (
    .aluop_i       (aluop),
    .funct_i       (bus.Funct),
    .alu_control_o (alu_control)
  );

  assign bus.PCWrite    = ctrl.pc_write;
  assign bus.PCSrc      = ctrl.pc_src;
  assign bus.RegWrite   = ctrl.reg_write;
  assign bus.IorD       = ctrl.iord;
  assign bus.MemWrite   = ctrl.mem_write;
  assign bus.IRWrite    = ctrl.ir_write;
  assign bus.RegDst     = ctrl.reg_dst;
  assign bus.MemtoReg   = ctrl.mem_to_reg;
  assign bus.ALUSrcA    = ctrl.alu_src_a;
  assign bus.ALUSrcB    = ctrl.alu_src_b;
  assign bus.ALUControl = alu_control;
  assign state_o        = state_q;

endmodule

// File: rtl/multicycle_control.sv
// Main control unit for the multicycle MIPS core; flat DataPath-facing ports
// bundled internally onto the controller interface.
module multicycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         Op,
  input  logic [5:0]         Funct,
  input  logic               Zero,
  output logic               PCWrite,
  output logic               PCSrc,
  output logic               RegWrite,
  output logic               IorD,
  output logic               MemWrite,
  output logic               IRWrite,
  output logic               RegDst,
  output logic               MemtoReg,
  output logic               ALUSrcA,
  output logic [1:0]         ALUSrcB,
  output logic [2:0]         ALUControl,
  output logic [STATE_W-1:0] state_o
);

  multicycle_control_if ctrl_bus ();
  state_t state;

  assign ctrl_bus.Op    = Op;
  assign ctrl_bus.Funct = Funct;
  assign ctrl_bus.Zero  = Zero;

  // reset is active-low and asynchronous; it feeds the FSM register directly.
  multicycle_control_fsm u_fsm (
    .clk     (clk),
    .rst_n   (reset),
    .bus     (ctrl_bus),
    .state_o (state)
  );

  assign PCWrite    = ctrl_bus.PCWrite;
  assign PCSrc      = ctrl_bus.PCSrc;
  assign RegWrite   = ctrl_bus.RegWrite;
  assign IorD       = ctrl_bus.IorD;
  assign MemWrite   = ctrl_bus.MemWrite;
  assign IRWrite    = ctrl_bus.IRWrite;
  assign RegDst     = ctrl_bus.RegDst;
  assign MemtoReg   = ctrl_bus.MemtoReg;
  assign ALUSrcA    = ctrl_bus.ALUSrcA;
  assign ALUSrcB    = ctrl_bus.ALUSrcB;
  assign ALUControl = ctrl_bus.ALUControl;
  assign state_o    = STATE_W'(state);

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control unit for the multicycle MIPS core. A Moore state machine that consumes `Op`, `Funct` and `Zero` from `DataPath` and drives every `DataPath` control input, one microstep per clock. It replaces the hand-sequenced control stimulus with a self-timed instruction sequence.

## Interface
- `STATE_W`, default 4: width of the state register and of `state_o`.
- `clk`, input, 1: system clock; all state updates on the rising edge.
- `reset`, input, 1: asynchronous, active-low reset.
- `Op`, input, 6: `Instr[31:26]` from the `DataPath` instruction register.
- `Funct`, input, 6: `Instr[5:0]` from the instruction register.
- `Zero`, input, 1: ALU zero flag from `DataPath`; `DataPath` exposes this port.
- `PCWrite`, output, 1: PC load enable. It is already ORed with the branch condition.
- `PCSrc`, output, 1: PC source; 0 selects the ALU result, 1 selects ALUOut.
- `RegWrite`, output, 1: register file write enable.
- `IorD`, output, 1: memory address select; 0 selects PC, 1 selects ALUOut.
- `MemWrite`, output, 1: memory write enable.
- `IRWrite`, output, 1: instruction register load enable.
- `RegDst`, output, 1: destination register select; 0 selects rt, 1 selects rd.
- `MemtoReg`, output, 1: write-back data select; 0 selects ALUOut, 1 selects memory data.
- `ALUSrcA`, output, 1: ALU A operand; 0 selects PC, 1 selects register A.
- `ALUSrcB`, output, 2: ALU B operand; 00 selects B, 01 selects 4, 10 selects SignImm, 11 selects SignImm<<2.
- `ALUControl`, output, 3: 010 add, 110 sub, 000 and, 001 or, 111 slt.
- `state_o`, output, `STATE_W`: current state, for debug and verification.

## Operation
- States and their encodings:
  - FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5.
  - EXEC=6, ALUWB=7, BRANCH=8, ADDIEX=9, ADDIWB=10.
- Transitions:
  - FETCH→DECODE.
  - DECODE branches on `Op`:
    - 6'h23 (lw) or 6'h2B (sw) → MEMADR.
    - 6'h00 (R-type) → EXEC.
    - 6'h04 (beq) → BRANCH.
    - 6'h08 (addi) → ADDIEX.
    - Any other opcode → FETCH; the instruction is treated as a NOP.
  - MEMADR→MEMRD for lw, MEMADR→MEMWR for sw.
  - MEMRD→MEMWB→FETCH.
  - MEMWR→FETCH.
  - EXEC→ALUWB→FETCH.
  - BRANCH→FETCH.
  - ADDIEX→ADDIWB→FETCH.
  - Unused encodings 11–15 → FETCH.
- Outputs asserted per state; every output not listed is 0:
  - FETCH: IRWrite=1, PCWrite=1, ALUSrcB=01, ALU add.
  - DECODE: ALUSrcB=11, ALU add. This precomputes the branch target into ALUOut.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALU add.
  - MEMRD: IorD=1.
  - MEMWB: RegWrite=1, MemtoReg=1, RegDst=0.
  - MEMWR: IorD=1, MemWrite=1.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUControl taken from `Funct`.
  - ALUWB: RegWrite=1, RegDst=1.
  - BRANCH: ALUSrcA=1, ALUSrcB=00, ALU sub, PCSrc=1, PCWrite=`Zero`.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALU add.
  - ADDIWB: RegWrite=1, RegDst=0.
- Funct decode, applied in EXEC only:
  - 6'h20 → 010; 6'h22 → 110; 6'h24 → 000; 6'h25 → 001; 6'h2A → 111.
  - Any other funct → 010; write-back still occurs.
- Internal ALUOp: 00=add, 01=sub, 10=use funct.

## Timing
- Reset:
  - `reset`=0 forces the state to FETCH immediately, without waiting for `clk`, including mid-instruction.
  - While in reset, outputs are the FETCH values. `DataPath` is held in the same reset, so these writes are harmless.
  - The first rising edge after `reset` rises moves the state to DECODE.
- Output logic:
  - All outputs are combinational decodes of the state register; no output is registered.
  - `PCWrite` additionally depends combinationally on `Zero`, in BRANCH only.
- Input sampling:
  - `Op` is sampled only at the DECODE→next and MEMADR→next edges.
  - `Funct` is used only during EXEC.
  - Both are stable because IRWrite is high in FETCH only.
- Cycles per instruction, counted from the FETCH state to the return to FETCH:
  - lw 5; sw 4; R-type 4; addi 4; beq 3; illegal opcode 2.
- Register-write timing: RegWrite is high for exactly one cycle per writing instruction, and never in the same cycle as MemWrite.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - state encodings;
  - opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI);
  - funct constants;
  - ALUControl codes;
  - ALUSrcB codes;
  - ALUOp codes.
- Sub-module `alu_decoder` is a combinational block that maps ALUOp and `Funct` to ALUControl.
- The FSM is written as a state register plus next-state and output logic.

## Test plan
- lw: release reset with Op=6'h23.
  - `state_o` must read 0,1,2,3,4,0.
  - In state 4: RegWrite=1, MemtoReg=1, RegDst=0.
  - In state 3: IorD=1.
- sw: Op=6'h2B.
  - `state_o` must read 0,1,2,5,0.
  - MemWrite=1 and IorD=1 for exactly one cycle; RegWrite stays 0 throughout.
- R-type: Op=0 with each Funct in turn: 6'h20, 6'h22, 6'h24, 6'h25, 6'h2A, and 6'h3F.
  - ALUControl in EXEC must be 010, 110, 000, 001, 111, and 010 respectively.
  - ALUWB must show RegDst=1 and RegWrite=1.
- beq: Op=6'h04.
  - With Zero=1: PCWrite=1, PCSrc=1, ALUControl=110 in state 8.
  - With Zero=0: PCWrite=0 in state 8.
  - Toggling Zero within state 8 must follow on PCWrite combinationally.
- addi, then illegal opcode:
  - Op=6'h08 gives the sequence 0,1,9,10,0; state 9 shows ALUSrcB=10.
  - Op=6'h3F gives the sequence 0,1,0.
- Asynchronous reset mid-instruction: drop `reset` mid-cycle while in MEMRD.
  - `state_o` must be 0 before the next clock edge.
  - MemWrite and RegWrite stay 0.
  - After `reset` is released, fetch resumes normally.
